// File: rtl/aes_gcm_pkg.sv
// rtl/aes_gcm_pkg.sv - AES block type, S-box and round primitive functions.
package aes_gcm_pkg;

  typedef logic [127:0] block_t;

  // Byte x of the S-box lives at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic block_t sub_bytes(input block_t s);
    block_t o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Block byte r+4c is state row r, column c.
  function automatic block_t shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - combinational AES round; final rounds skip MixColumns.
module aes_round
  import aes_gcm_pkg::*;
(
  input  block_t state_in,
  input  block_t round_key_in,
  input  logic   final_in,
  output block_t state_out
);

  block_t shifted;

  always_comb begin
    shifted   = shift_rows(sub_bytes(state_in));
    state_out = (final_in ? shifted : mix_columns(shifted)) ^ round_key_in;
  end

endmodule

// File: rtl/aes_ctr_round_stage.sv
// rtl/aes_ctr_round_stage.sv - one registered AES-CTR round over LANES blocks.
// AES_STAGE_SKID_EN selects a 2-entry skid buffer with a registered o_ready.
module aes_ctr_round_stage
  import aes_gcm_pkg::*;
#(
  parameter int NR     = 10,
  parameter int ROUND  = 1,
  parameter int LANES  = 1,
  parameter int SIDE_W = 513
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [128*LANES-1:0]  i_state,
  input  logic [128*LANES-1:0]  i_text,
  input  logic [128*(NR+1)-1:0] i_key_schedule,
  input  logic [SIDE_W-1:0]     i_side,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [128*LANES-1:0]  o_state,
  output logic [128*(NR+1)-1:0] o_key_schedule,
  output logic [SIDE_W-1:0]     o_side
);

  localparam int   SW       = 128*LANES;
  localparam int   KW       = 128*(NR+1);
  localparam int   KEY_LSB  = 128*(NR-ROUND);
  localparam logic IS_FINAL = (ROUND == NR);

  generate
    if (!(NR == 10 || NR == 12 || NR == 14) || ROUND < 1 || ROUND > NR) begin : g_bad_params
      $fatal(1, "aes_ctr_round_stage: illegal NR/ROUND combination");
    end
  endgenerate

  typedef struct packed {
    logic [SW-1:0]     state;
    logic [SW-1:0]     text;
    logic [KW-1:0]     ks;
    logic [SIDE_W-1:0] side;
  } entry_t;

  entry_t in_entry, main_q, main_d;
  logic   valid_q, valid_d;
  logic   accept, out_fire;

  assign in_entry = {i_state, i_text, i_key_schedule, i_side};
  assign out_fire = valid_q && i_ready;
  assign accept   = i_valid && o_ready;

`ifdef AES_STAGE_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   ready_q, ready_d;

  // ready_q is 1 out of reset; rst masks it so o_ready stays low while held.
  assign o_ready = ready_q && !rst;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (out_fire) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!valid_q || out_fire) begin
        main_d  = in_entry;
        valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end
`else
  assign o_ready = !rst && (!valid_q || i_ready);

  always_comb begin
    main_d  = main_q;
    valid_d = valid_q;
    if (accept) begin
      main_d  = in_entry;
      valid_d = 1'b1;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
  end
`endif

  assign o_valid        = valid_q;
  assign o_key_schedule = main_q.ks;
  assign o_side         = main_q.side;

  // Lane 0 occupies the most significant 128 bits.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    block_t rnd;
    aes_round u_round (
      .state_in     (main_q.state[128*(LANES-1-l) +: 128]),
      .round_key_in (main_q.ks[KEY_LSB +: 128]),
      .final_in     (IS_FINAL),
      .state_out    (rnd)
    );
    assign o_state[128*(LANES-1-l) +: 128] =
      IS_FINAL ? (rnd ^ main_q.text[128*(LANES-1-l) +: 128]) : rnd;
  end

endmodule

// File: tb/tb_aes_ctr_round_stage.sv
// tb/tb_aes_ctr_round_stage.sv - scoreboard bench for first- and last-round stages.
module tb_aes_ctr_round_stage;

  localparam int NR     = 10;
  localparam int LANES  = 4;
  localparam int SIDE_W = 513;
  localparam int SW     = 128*LANES;
  localparam int KW     = 128*(NR+1);

  typedef struct packed {
    logic [SW-1:0]     st_a;
    logic [SW-1:0]     st_b;
    logic [KW-1:0]     ks;
    logic [SIDE_W-1:0] side;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0;
  logic [SW-1:0]     i_state = '0, i_text = '0;
  logic [KW-1:0]     i_ks = '0;
  logic [SIDE_W-1:0] i_side = '0;

  logic              o_ready_a, o_valid_a, o_ready_b, o_valid_b;
  logic [SW-1:0]     o_state_a, o_state_b;
  logic [KW-1:0]     o_ks_a, o_ks_b;
  logic [SIDE_W-1:0] o_side_a, o_side_b;

  int   n_tests = 0, n_fail = 0;
  logic [7:0] sbox_m [256];
  exp_t q[$];
  exp_t pend_e;
  logic pend_v = 1'b0;
  logic [SW-1:0]     cur_state, cur_text;
  logic [KW-1:0]     cur_ks;
  logic [SIDE_W-1:0] cur_side;

  aes_ctr_round_stage #(.NR(NR), .ROUND(1), .LANES(LANES), .SIDE_W(SIDE_W)) u_dut_first (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_a), .i_state(i_state),
    .i_text(i_text), .i_key_schedule(i_ks), .i_side(i_side), .o_valid(o_valid_a),
    .i_ready(i_ready), .o_state(o_state_a), .o_key_schedule(o_ks_a), .o_side(o_side_a)
  );

  aes_ctr_round_stage #(.NR(NR), .ROUND(NR), .LANES(LANES), .SIDE_W(SIDE_W)) u_dut_last (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_b), .i_state(i_state),
    .i_text(i_text), .i_key_schedule(i_ks), .i_side(i_side), .o_valid(o_valid_b),
    .i_ready(i_ready), .o_state(o_state_b), .o_key_schedule(o_ks_b), .o_side(o_side_b)
  );

  task automatic check(input string name, input logic [512:0] act, input logic [512:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
  task automatic build_sbox();
    logic [7:0] inv, xb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, xb);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic [127:0] text, input bit fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   m [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox_m[st[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) t[rw+4*c] = b[rw+4*((c+rw)%4)];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        m[rw+4*c] = fin ? t[rw+4*c] :
                    gmul(8'h02, t[4*c+rw]) ^ gmul(8'h03, t[4*c+(rw+1)%4]) ^
                    t[4*c+(rw+2)%4] ^ t[4*c+(rw+3)%4];
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m[i];
    r = r ^ key;
    if (fin) r = r ^ text;
    return r;
  endfunction

  function automatic exp_t model_beat(input logic [SW-1:0] st, input logic [SW-1:0] tx,
                                      input logic [KW-1:0] ks, input logic [SIDE_W-1:0] sd);
    exp_t e;
    e.ks   = ks;
    e.side = sd;
    for (int l = 0; l < LANES; l++) begin
      e.st_a[128*(LANES-1-l) +: 128] = model_round(st[128*(LANES-1-l) +: 128],
                                                   ks[128*(NR-1) +: 128], 128'h0, 1'b0);
      e.st_b[128*(LANES-1-l) +: 128] = model_round(st[128*(LANES-1-l) +: 128],
                                                   ks[0 +: 128], tx[128*(LANES-1-l) +: 128], 1'b1);
    end
    return e;
  endfunction

  task automatic new_beat();
    for (int w = 0; w < SW/32; w++) begin
      cur_state[32*w +: 32] = $urandom();
      cur_text[32*w +: 32]  = $urandom();
    end
    for (int w = 0; w < KW/32; w++) cur_ks[32*w +: 32] = $urandom();
    for (int w = 0; w < 16; w++) cur_side[32*w +: 32] = $urandom();
    cur_side[512] = 1'($urandom_range(0, 1));
  endtask

  // One cycle of stimulus; a beat enters the scoreboard after the edge that accepts it.
  task automatic drive(input logic v, input logic rdy, input logic r, output logic took);
    @(negedge clk);
    if (pend_v) begin
      q.push_back(pend_e);
      pend_v = 1'b0;
    end
    rst     = r;
    i_valid = v;
    i_ready = rdy;
    i_state = cur_state;
    i_text  = cur_text;
    i_ks    = cur_ks;
    i_side  = cur_side;
    #1;
    took = v && o_ready_a && !r;
    if (took) begin
      pend_e = model_beat(cur_state, cur_text, cur_ks, cur_side);
      pend_v = 1'b1;
    end
  endtask

  // Monitor: samples just before each rising edge.
  initial begin
    exp_t e;
    logic ev, er;
    forever begin
      @(negedge clk);
      #4;
      ev = (q.size() != 0);
`ifdef AES_STAGE_SKID_EN
      er = !rst && (q.size() < 2);
`else
      er = !rst && (q.size() == 0 || i_ready);
`endif
      check("valid_first", 513'(o_valid_a), 513'(ev));
      check("valid_last",  513'(o_valid_b), 513'(ev));
      check("ready_first", 513'(o_ready_a), 513'(er));
      check("ready_last",  513'(o_ready_b), 513'(er));
      if (ev) begin
        e = q[0];
        check("state_first", 513'(o_state_a), 513'(e.st_a));
        check("state_last",  513'(o_state_b), 513'(e.st_b));
        check("side_first",  o_side_a, e.side);
        check("side_last",   o_side_b, e.side);
        for (int k = 0; k <= NR; k++) begin
          check($sformatf("ks_first[%0d]", k), 513'(o_ks_a[128*k +: 128]), 513'(e.ks[128*k +: 128]));
          check($sformatf("ks_last[%0d]", k),  513'(o_ks_b[128*k +: 128]), 513'(e.ks[128*k +: 128]));
        end
      end
      if (rst) q.delete();
      else if (ev && i_ready) e = q.pop_front();
    end
  end

  initial begin
    logic took;
    int   sent, cyc;
    build_sbox();
    new_beat();
    repeat (3) drive(1'b0, 1'b0, 1'b1, took);
    drive(1'b0, 1'b0, 1'b0, took);

    // FIPS-197 C.1 vectors: round 1 on lane 0, final round on lane 1.
    cur_ks = '0;
    cur_ks[128*NR +: 128]     = 128'h000102030405060708090a0b0c0d0e0f;
    cur_ks[128*(NR-1) +: 128] = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    cur_ks[0 +: 128]          = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    cur_state[511 -: 128] = 128'h00102030405060708090a0b0c0d0e0f0;
    cur_state[383 -: 128] = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    cur_state[255 -: 128] = 128'h89d810e8855ace682d1843d8cb128fe4;
    cur_text = '0;
    drive(1'b1, 1'b1, 1'b0, took);
    check("golden_accept", 513'(took), 513'(1'b1));
    drive(1'b0, 1'b1, 1'b0, took);
    #3;
    check("golden_round1", 513'(o_state_a[511 -: 128]), 513'(128'h89d810e8855ace682d1843d8cb128fe4));
    check("golden_round10", 513'(o_state_b[383 -: 128]), 513'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));

    for (int i = 0; i < 20; i++) begin
      new_beat();
      drive(1'b1, 1'b1, 1'b0, took);
      check("full_rate_accept", 513'(took), 513'(1'b1));
    end

    sent = 0;
    cyc  = 0;
    new_beat();
    while (sent < 100 && cyc < 4000) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'b0, took);
      cyc++;
      if (took) begin
        sent++;
        new_beat();
      end
    end
    check("random_beats_sent", 513'(sent), 513'(100));

    repeat (4) drive(1'b0, 1'b1, 1'b0, took);
    #3;
    check("drain_empty", 513'(q.size()), 513'(0));

    new_beat();
    drive(1'b1, 1'b0, 1'b0, took);
    check("stall_accept", 513'(took), 513'(1'b1));
    drive(1'b0, 1'b0, 1'b0, took);
    drive(1'b0, 1'b0, 1'b1, took);
    drive(1'b0, 1'b0, 1'b0, took);
    repeat (4) drive(1'b0, 1'b1, 1'b0, took);
    #3;
    check("post_reset_empty", 513'(q.size()), 513'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_ctr_round_stage.md
AES_CTR_ROUND_STAGE -- requirements
Module: aes_ctr_round_stage

Interface
REQ-001 SHALL have parameter NR, default 10: total AES rounds; legal values 10, 12, 14 (AES-128/192/256).
REQ-002 SHALL have parameter ROUND, default 1: round index applied by this stage; legal range 1..NR.
REQ-003 SHALL have parameter LANES, default 1: independent counter blocks processed in parallel; legal range 1..8.
REQ-004 SHALL have parameter SIDE_W, default 513: width of opaque sideband (aad, h, instance_size, j0-state, new_instance).
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
REQ-006 SHALL have the following upstream ports.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  stage can accept a beat.
- i_state  in  128*LANES  per-lane AES state after round ROUND-1; lane 0 at MSBs.
- i_text  in  128*LANES  per-lane plaintext; used only when ROUND==NR.
- i_key_schedule  in  128*(NR+1)  expanded key; round key k at bits [128k +: 128] from MSB.
- i_side  in  SIDE_W  sideband; carried unmodified.
REQ-007 SHALL have the following downstream ports.
- o_valid  out  1  downstream beat valid.
- i_ready  in  1  downstream accepts.
- o_state  out  128*LANES  round output; ciphertext when ROUND==NR.
- o_key_schedule  out  128*(NR+1)  key schedule aligned with o_state.
- o_side  out  SIDE_W  sideband aligned with o_state.

Function
REQ-008 SHALL transfer a beat upstream when i_valid && o_ready, and downstream when o_valid && i_ready, both on a rising clk edge.
REQ-009 SHALL register i_state, i_text, i_key_schedule and i_side on accept, then compute the round from the registered values.
REQ-010 For ROUND<NR, SHALL output SubBytes, ShiftRows, MixColumns, then XOR round key ROUND.
REQ-011 For ROUND==NR, SHALL output SubBytes, ShiftRows, XOR round key NR, then XOR the registered i_text per lane.
REQ-012 SHALL have a latency of exactly 1 cycle from accept to o_valid when unstalled, with throughput of one beat per cycle.
REQ-013 SHALL keep o_valid asserted and hold all outputs stable while o_valid && !i_ready.
REQ-014 SHALL process lanes independently, sharing a single key schedule and a single sideband.
REQ-015 On simultaneous downstream transfer and upstream accept with the holding register full, SHALL replace the register contents with no bubble.
REQ-016 SHALL never drop or duplicate a beat under any i_ready pattern.
REQ-017 SHALL be rejected at elaboration (fatal) if ROUND is outside 1..NR or NR is not in {10,12,14}.

Reset
REQ-018 While rst is high, SHALL hold o_valid=0 and discard all stored beats; data registers are not reset.
REQ-019 SHALL drive o_ready=0 during reset and o_ready=1 on the first cycle after rst deasserts.
REQ-020 On reset mid-stall, SHALL lose the pending beat, with o_valid=0 in the cycle after reset is sampled.

Configuration
REQ-021 With macro AES_STAGE_SKID_EN defined, SHALL include a 2-entry skid buffer: o_ready is a registered signal (deasserted only when both entries are full) and no combinational path runs from i_ready to o_ready.
REQ-022 Without AES_STAGE_SKID_EN, SHALL use a single entry with o_ready = !o_valid || i_ready (combinational).
REQ-023 Latency and output values SHALL be identical in both configurations.

Structure
REQ-024 Package aes_gcm_pkg SHALL hold block_t (128-bit), the S-box, and functions for sub_bytes, shift_rows, mix_columns and xtime.
REQ-025 Sub-module aes_round (combinational: state, round key, final flag -> state) SHALL be instantiated once per lane.
REQ-026 The handshake/storage logic SHALL be local to aes_ctr_round_stage.

Verification
REQ-027 NR=10, ROUND=1, LANES=1, state 00102030405060708090a0b0c0d0e0f0, key0=000102...0f -> o_state 89d810e8855ace682d1843d8cb128fe4 one cycle later.
REQ-028 ROUND=10, state bd6e7c3df2b5779e0b61216e8b10b689, round key 13111d7fe3944a17f307a78b4d2b30c5, i_text 0 -> o_state 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-029 LANES=4, each lane given a distinct FIPS-197 round state -> each lane matches its golden value independently; o_side equals i_side bit-exact.
REQ-030 Back-to-back 100 beats with random i_ready (50%) -> output sequence in order with no loss or duplication; with skid enabled, full throughput whenever i_ready=1.
REQ-031 Assert rst while o_valid=1 and i_ready=0 -> o_valid=0 the next cycle and o_ready=1 after release; no stale beat emitted.
